// File: rtl/palette_loader.sv
// Streams an R,G,B byte file from the download channel into the 64-entry palette RAM.
// Optional: define PAL_LOADER_CKSUM_EN to build the 16-bit additive checksum of accepted bytes.
module palette_loader #(
    parameter int ENTRIES     = 64,
    parameter int EXT_ENTRIES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [15:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    input  logic        load_ok,
    output logic        load_color,
    output logic [5:0]  load_color_index,
    output logic [23:0] load_color_data,
    output logic        busy,
    output logic        pal_valid,
    output logic        pal_error,
    output logic [15:0] cksum
);
    localparam int CW = $clog2(EXT_ENTRIES * 3 + 1);
    localparam int EW = $clog2(EXT_ENTRIES + 1);
    localparam logic [CW-1:0] SHORT_LEN = CW'(ENTRIES * 3);
    localparam logic [CW-1:0] LONG_LEN  = CW'(EXT_ENTRIES * 3);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic          act_q;
    logic          hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    comp_q, comp_d;
    logic [EW-1:0] ent_q, ent_d;
    logic [7:0]    r_q, r_d, g_q, g_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic [5:0]    pidx_q, pidx_d;
    logic [23:0]   pdata_q, pdata_d;
    logic          wr_q, wr_d;
    logic [5:0]    idx_q, idx_d;
    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d, perr_q, perr_d;
    logic          rise, start, accept, complete;
    logic [5:0]    cidx;
    logic [23:0]   cdata;

    assign rise = dl_active & ~act_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        comp_d   = comp_q;
        ent_d    = ent_q;
        r_d      = r_q;
        g_d      = g_q;
        err_d    = err_q;
        pend_d   = pend_q;
        pidx_d   = pidx_q;
        pdata_d  = pdata_q;
        wr_d     = 1'b0;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        start    = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        cidx     = ent_q[5:0];
        cdata    = {r_q, g_q, dl_data};

        case (state_q)
            IDLE:  if (rise) start = 1'b1;
            LOAD:  if (!dl_active) state_d = FLUSH;
            FLUSH: begin
                // A new download arriving now waits until the last write has drained.
                if (rise) hold_d = 1'b1;
                if (!pend_q) begin
                    state_d = DONE;
                    valid_d = !err_q && (cnt_q == SHORT_LEN || cnt_q == LONG_LEN);
                    perr_d  = !valid_d;
                end
            end
            DONE:  if (rise || hold_q) start = 1'b1;
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = LOAD;
            hold_d  = 1'b0;
            cnt_d   = '0;
            comp_d  = '0;
            ent_d   = '0;
            err_d   = 1'b0;
            valid_d = 1'b0;
            perr_d  = 1'b0;
        end

        if (state_q == LOAD && dl_wr) begin
            if (pend_q || dl_addr != 16'(cnt_q) || cnt_q == LONG_LEN)
                err_d = 1'b1;
            else
                accept = 1'b1;
        end

        if (accept) begin
            cnt_d = cnt_q + CW'(1);
            case (comp_q)
                2'd0: begin r_d = dl_data; comp_d = 2'd1; end
                2'd1: begin g_d = dl_data; comp_d = 2'd2; end
                default: begin
                    comp_d   = 2'd0;
                    ent_d    = ent_q + EW'(1);
                    complete = (ent_q < EW'(ENTRIES));
                end
            endcase
        end

        // A freshly completed entry bypasses the pending slot when the RAM is free.
        if (complete) begin
            if (load_ok) begin
                wr_d   = 1'b1;
                idx_d  = cidx;
                data_d = cdata;
            end else begin
                pend_d  = 1'b1;
                pidx_d  = cidx;
                pdata_d = cdata;
            end
        end else if (pend_q && load_ok) begin
            wr_d   = 1'b1;
            idx_d  = pidx_q;
            data_d = pdata_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            comp_q  <= '0;
            ent_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            pdata_q <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= dl_active;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
            ent_q   <= ent_d;
            r_q     <= r_d;
            g_q     <= g_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            pdata_q <= pdata_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

`ifdef PAL_LOADER_CKSUM_EN
    logic [15:0] ck_q;
    always_ff @(posedge clk) begin
        if (reset || start) ck_q <= '0;
        else if (accept)    ck_q <= ck_q + 16'(dl_data);
    end
    assign cksum = ck_q;
`else
    assign cksum = '0;
`endif

    assign dl_wait          = pend_q;
    assign load_color       = wr_q;
    assign load_color_index = idx_q;
    assign load_color_data  = data_q;
    assign busy             = (state_q == LOAD) || (state_q == FLUSH);
    assign pal_valid        = valid_q;
    assign pal_error        = perr_q;
endmodule

// File: tb/tb_palette_loader.sv
// Randomized self-checking bench for palette_loader; expected RAM writes come from the byte file itself.
module tb_palette_loader;
    logic        clk = 1'b0;
    logic        reset, dl_active, dl_wr, load_ok;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait, load_color, busy, pal_valid, pal_error;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic [15:0] cksum;

    palette_loader dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .load_ok(load_ok),
        .load_color(load_color), .load_color_index(load_color_index),
        .load_color_data(load_color_data), .busy(busy), .pal_valid(pal_valid),
        .pal_error(pal_error), .cksum(cksum)
    );

    always #5 clk = ~clk;

    int          vecs = 0, miscmp = 0;
    logic [7:0]  fb [0:1535];
    logic [29:0] got_q[$];
    logic [29:0] exp_q[$];
    int          wait_cyc, bad_pulse;
    logic        lok_s = 1'b0;
    bit          rnd_ok;

    // Monitor: log every RAM write and flag writes not licensed by load_ok at the edge.
    always @(posedge clk) lok_s <= load_ok;
    always @(negedge clk) begin
        if (!reset) begin
            if (load_color) begin
                got_q.push_back({load_color_index, load_color_data});
                if (!lok_s) bad_pulse++;
            end
            if (dl_wait) wait_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: every complete triple below entry 64 becomes one write, in order.
    function automatic int write_diffs(input int nbytes);
        int d = 0;
        exp_q.delete();
        for (int k = 0; k < nbytes / 3 && k < 64; k++)
            exp_q.push_back({6'(k), fb[3*k], fb[3*k+1], fb[3*k+2]});
        if (exp_q.size() != got_q.size()) return 1000 + got_q.size();
        foreach (exp_q[i]) if (exp_q[i] !== got_q[i]) d++;
        return d;
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic start_dl();
        got_q.delete();
        wait_cyc  = 0;
        bad_pulse = 0;
        dl_wr     = 1'b0;
        dl_active = 1'b1;
        tick();
        vecs++;
        if ({busy, pal_valid, pal_error, cksum} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            miscmp++;
            $display("FAIL start busy/valid/err/cksum=%b/%b/%b/%h required 1/0/0/0000",
                     busy, pal_valid, pal_error, cksum);
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        int n = 0;
        while (dl_wait === 1'b1 && n < 200) begin
            if (rnd_ok) load_ok = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (n >= 200) begin
            vecs++; miscmp++;
            $display("FAIL wait_bound dl_wait=%b after 200 cycles, required 0", dl_wait);
        end
        if (rnd_ok) load_ok = 1'($urandom_range(0, 1));
        dl_wr   = 1'b1;
        dl_addr = 16'(a);
        dl_data = d;
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic finish_dl();
        int n = 0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        load_ok   = 1'b1;
        tick();
        while (busy === 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            vecs++; miscmp++;
            $display("FAIL flush_bound busy=%b after 100 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; load_ok = 1'b1;
        dl_addr = '0; dl_data = '0; rnd_ok = 1'b0;
        tick(); tick();
        reset = 1'b0;
        vecs++;
        if ({dl_wait, load_color, load_color_index, load_color_data, busy, pal_valid, pal_error, cksum} !== '0) begin
            miscmp++;
            $display("FAIL reset_state wait=%b lc=%b idx=%h data=%h busy=%b v=%b e=%b ck=%h required all 0",
                     dl_wait, load_color, load_color_index, load_color_data, busy, pal_valid, pal_error, cksum);
        end
    endtask

    task automatic test_seq192();
        int d;
        for (int i = 0; i < 192; i++) fb[i] = 8'(i);
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 192; i++) begin
            dl_wr = 1'b1; dl_addr = 16'(i); dl_data = fb[i];
            tick();
            vecs++;
            if (load_color !== (i % 3 == 2) ||
                (i % 3 == 2 && {load_color_index, load_color_data} !== {6'(i / 3), fb[i-2], fb[i-1], fb[i]})) begin
                miscmp++;
                $display("FAIL seq_latency byte %0d lc=%b idx=%h data=%h, required lc=%b idx=%h data=%h%h%h",
                         i, load_color, load_color_index, load_color_data, (i % 3 == 2), 6'(i / 3),
                         fb[(i/3)*3], fb[(i/3)*3+1], fb[(i/3)*3+2]);
            end
        end
        finish_dl();
        d = write_diffs(192);
        vecs++;
        if (d !== 0 || wait_cyc !== 0 || bad_pulse !== 0) begin
            miscmp++;
            $display("FAIL seq_writes diffs=%0d wait_cycles=%0d bad_pulses=%0d, required 0/0/0", d, wait_cyc, bad_pulse);
        end
        vecs++;
        if ({pal_valid, pal_error, busy} !== 3'b100) begin
            miscmp++;
            $display("FAIL seq_status v/e/busy=%b%b%b required 100", pal_valid, pal_error, busy);
        end
    endtask

    task automatic test_ext1536();
        int d;
        fill_rand(1536);
        rnd_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 1536; i++) send_byte(i, fb[i]);
        rnd_ok = 1'b0;
        finish_dl();
        d = write_diffs(1536);
        vecs++;
        if (d !== 0 || bad_pulse !== 0) begin
            miscmp++;
            $display("FAIL ext_writes diffs=%0d writes=%0d bad_pulses=%0d, required 0 diffs, 64 writes, 0 bad",
                     d, got_q.size(), bad_pulse);
        end
        vecs++;
        if ({pal_valid, pal_error} !== 2'b10) begin
            miscmp++;
            $display("FAIL ext_status v/e=%b%b required 10", pal_valid, pal_error);
        end
    endtask

    task automatic test_stall();
        int d;
        fill_rand(192);
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        send_byte(0, fb[0]);
        send_byte(1, fb[1]);
        load_ok = 1'b0;
        send_byte(2, fb[2]);
        for (int c = 1; c <= 10; c++) begin
            vecs++;
            if (dl_wait !== 1'b1 || load_color !== 1'b0) begin
                miscmp++;
                $display("FAIL stall_wait cycle %0d dl_wait=%b lc=%b, required 1/0", c, dl_wait, load_color);
            end
            load_ok = (c == 10);
            dl_wr   = (c == 4);
            dl_addr = 16'd3;
            dl_data = fb[3];
            tick();
            dl_wr = 1'b0;
        end
        vecs++;
        if ({load_color, dl_wait, load_color_index, load_color_data} !== {1'b1, 1'b0, 6'd0, fb[0], fb[1], fb[2]}) begin
            miscmp++;
            $display("FAIL stall_release lc=%b wait=%b idx=%h data=%h, required 1/0/00/%h%h%h",
                     load_color, dl_wait, load_color_index, load_color_data, fb[0], fb[1], fb[2]);
        end
        for (int i = 3; i < 192; i++) send_byte(i, fb[i]);
        finish_dl();
        d = write_diffs(192);
        vecs++;
        if (d !== 0 || wait_cyc !== 10 || bad_pulse !== 0) begin
            miscmp++;
            $display("FAIL stall_writes diffs=%0d wait_cycles=%0d bad=%0d, required 0/10/0", d, wait_cyc, bad_pulse);
        end
        vecs++;
        if ({pal_valid, pal_error} !== 2'b01) begin
            miscmp++;
            $display("FAIL stall_status v/e=%b%b required 01", pal_valid, pal_error);
        end
    endtask

    task automatic test_short100();
        int d;
        fill_rand(100);
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 100; i++) send_byte(i, fb[i]);
        finish_dl();
        d = write_diffs(100);
        vecs++;
        if (d !== 0 || got_q.size() !== 33 || {pal_valid, pal_error} !== 2'b01) begin
            miscmp++;
            $display("FAIL short100 diffs=%0d writes=%0d v/e=%b%b, required 0/33/01",
                     d, got_q.size(), pal_valid, pal_error);
        end
    endtask

    task automatic test_addr_skip();
        int d;
        fill_rand(8);
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 6; i++) send_byte(i, fb[i]);
        send_byte(7, fb[7]);
        finish_dl();
        d = write_diffs(6);
        vecs++;
        if (d !== 0 || {pal_valid, pal_error} !== 2'b01) begin
            miscmp++;
            $display("FAIL addr_skip diffs=%0d writes=%0d v/e=%b%b, required 0/2/01",
                     d, got_q.size(), pal_valid, pal_error);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        fill_rand(50);
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 50; i++) send_byte(i, fb[i]);
        reset = 1'b1; dl_active = 1'b0;
        tick();
        vecs++;
        if ({dl_wait, load_color, load_color_index, load_color_data, busy, pal_valid, pal_error, cksum} !== '0) begin
            miscmp++;
            $display("FAIL reset_mid wait=%b lc=%b idx=%h data=%h busy=%b v=%b e=%b ck=%h required all 0",
                     dl_wait, load_color, load_color_index, load_color_data, busy, pal_valid, pal_error, cksum);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            dl_wr = c[0]; dl_addr = 16'(50 + c); dl_data = 8'hA5;
            tick();
        end
        dl_wr = 1'b0;
        d = write_diffs(48);
        vecs++;
        if (d !== 0 || busy !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_abort diffs=%0d writes=%0d busy=%b, required 0/16/0", d, got_q.size(), busy);
        end
    endtask

    task automatic test_cksum();
        for (int i = 0; i < 192; i++) fb[i] = 8'hFF;
        rnd_ok = 1'b0; load_ok = 1'b1;
        start_dl();
        for (int i = 0; i < 192; i++) send_byte(i, fb[i]);
        finish_dl();
        vecs++;
`ifdef PAL_LOADER_CKSUM_EN
        if (cksum !== 16'hBF40 || pal_valid !== 1'b1) begin
            miscmp++;
            $display("FAIL cksum value=%h valid=%b, required BF40/1", cksum, pal_valid);
        end
`else
        if (cksum !== 16'h0000 || pal_valid !== 1'b1) begin
            miscmp++;
            $display("FAIL cksum value=%h valid=%b, required 0000/1", cksum, pal_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_seq192();
        test_ext1536();
        test_stall();
        test_short100();
        test_addr_skip();
        test_cksum();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/palette_loader.md
# palette_loader

Streams a user palette file from the HPS download channel into the 64-entry custom palette RAM of the video output block. It assembles R,G,B bytes into 24-bit entries and writes them through that block's `load_color` / `load_color_index` / `load_color_data` port, pacing writes with a `load_ok` qualifier. It applies back-pressure via `dl_wait` and reports whether a complete, well-formed palette was received.

## Interface
Parameters:
- `ENTRIES`, 64: palette entries written to RAM; index width is 6.
- `EXT_ENTRIES`, 512: entries in an extended (emphasis) file; entries ≥ `ENTRIES` are accepted but not written.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `dl_active`  in  1  palette download in progress (level)
- `dl_wr`  in  1  byte strobe, one cycle per byte
- `dl_addr`  in  16  byte address within file
- `dl_data`  in  8  byte value
- `dl_wait`  out  1  loader cannot accept a byte this cycle
- `load_ok`  in  1  palette RAM write permitted at the next edge
- `load_color`  out  1  one-cycle RAM write strobe
- `load_color_index`  out  6  entry index being written
- `load_color_data`  out  24  {R,G,B}
- `busy`  out  1  state ≠ IDLE and ≠ DONE
- `pal_valid`  out  1  last download complete and error-free (sticky until next download)
- `pal_error`  out  1  last download malformed (sticky until next download)
- `cksum`  out  16  additive checksum of accepted bytes (only with `PAL_LOADER_CKSUM_EN`)

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE→LOAD on `dl_active` rising.
  - LOAD→FLUSH on `dl_active` falling.
  - FLUSH→DONE when no entry pending.
  - DONE→LOAD on the next `dl_active` rising.
- Entering LOAD clears the byte counter, component counter, `pal_valid`, `pal_error` and `cksum`.
- Byte mapping: byte n → entry n/3, component n%3 (0=R, 1=G, 2=B).
  - An accepted byte must have `dl_addr` == byte counter; a mismatch sets the sticky error and the byte is dropped.
- A third component completes an entry. If entry index < 64, the entry is latched into the pending register. Entries ≥ 64 are counted only.
- Pending register: one entry deep.
  - `dl_wait` = pending.
  - `dl_wr` while `dl_wait`=1 drops the byte and sets the sticky error.
- Write issue: at each edge, if an entry is pending (or completes at this edge) and `load_ok`=1, then `load_color`←1 for one cycle with index/data from that entry, and pending is cleared.
- Completion (FLUSH→DONE):
  - `pal_valid`←1 iff there is no sticky error and the byte count is 192 or 1536.
  - Otherwise `pal_error`←1.
  - Entries already written stay in RAM.
- Byte counter saturates at 1536; bytes beyond that set the error and are dropped.
- `dl_active` falling mid-entry (count % 3 ≠ 0) → `pal_error`; the partial entry is discarded.
- `dl_wr` outside LOAD is ignored.
- A new `dl_active` rising during FLUSH is held until DONE, so the pending write always completes first.

## Timing
- Reset values: state IDLE, `load_color` 0, `load_color_index` 0, `load_color_data` 0, `dl_wait` 0, `busy` 0, `pal_valid` 0, `pal_error` 0, `cksum` 0, pending 0.
- Reset mid-download aborts immediately. No further writes are issued; RAM contents are left as they are.
- Latency: B byte accepted at edge t with `load_ok`=1 at t → `load_color`=1 during cycle t+1.
- With `load_ok` low, the entry waits in pending and `dl_wait` is high from t+1. `load_color` pulses in the cycle after the first edge with `load_ok`=1, and `dl_wait` falls in that same cycle.
- Peak throughput: one byte per cycle while `load_ok` stays high; `dl_wait` never asserts in that case.
- `pal_valid`/`pal_error` update in the cycle after FLUSH exits. `busy` falls in that same cycle.

## Configuration
- `PAL_LOADER_CKSUM_EN` defined:
  - `cksum` = 16-bit wrap-around sum of every accepted byte, all 1536 included.
  - Updated one cycle after each accepted byte.
- Not defined: `cksum` is tied to 0 and the adder is not built.

## Test plan
- 192 sequential bytes 0x00..0xBF, `load_ok`=1 → 64 pulses; entry 0 = 0x000102, entry 63 = 0xBDBEBF; `dl_wait` never high; `pal_valid`=1.
- 1536-byte file → exactly 64 `load_color` pulses; `pal_valid`=1; no write for entries 64..511.
- `load_ok`=0 for 10 cycles after byte 2 → `dl_wait` high 10 cycles; a `dl_wr` during that window is dropped → `pal_error`=1 at end.
- 100-byte file → 33 writes, then `pal_error`=1, `pal_valid`=0.
- `dl_addr` skips from 5 to 7 → byte dropped; `pal_error`=1 after `dl_active` falls.
- Reset asserted after byte 50 → all outputs return to reset values next cycle; no further `load_color`. With `PAL_LOADER_CKSUM_EN`, a 192×0xFF file gives `cksum`=0xBF40.
